// File: rtl/mem_rd_arbiter_if.sv
// mem_rd_arbiter_if: read request, MAC request and response signals for mem_rd_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever drives the initiators and the MAC, such as a bench or a wrapper.
interface mem_rd_arbiter_if #(
    parameter int NUM_INIT = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TW       = 4,
    parameter int QW       = 4,
    parameter int SW       = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1
);
    // initiator request side
    logic [NUM_INIT-1:0]    iValidRd;
    logic [NUM_INIT*AW-1:0] iAddrRd;
    logic [NUM_INIT*TW-1:0] iTagRd;
    logic [NUM_INIT*2-1:0]  iLenRd;
    logic [NUM_INIT*QW-1:0] iQoSRd;
    logic [NUM_INIT-1:0]    oReadyRd;

    // MAC request side
    logic                   oMAC_ValidRd;
    logic [AW-1:0]          oMAC_AddrRd;
    logic [SW+TW-1:0]       oMAC_TagRd;
    logic [1:0]             oMAC_LenRd;
    logic [QW-1:0]          oMAC_QoSRd;
    logic                   iMAC_ReadyRd;

    // MAC response side
    logic                   iMAC_ValidRsp;
    logic [SW+TW-1:0]       iMAC_TagRsp;
    logic [DW-1:0]          iMAC_DataRsp;
    logic [1:0]             iMAC_StatusRsp;
    logic                   iMAC_EoD;
    logic                   oMAC_ReadyRsp;

    // initiator response side
    logic [NUM_INIT-1:0]    oValidRsp;
    logic [NUM_INIT*TW-1:0] oTagRsp;
    logic [NUM_INIT*DW-1:0] oDataRsp;
    logic [NUM_INIT*2-1:0]  oStatusRsp;
    logic [NUM_INIT-1:0]    oEoD;
    logic [NUM_INIT-1:0]    iReadyRsp;
    logic                   oErrRsp;

    modport slave (
        input  iValidRd, iAddrRd, iTagRd, iLenRd, iQoSRd,
        output oReadyRd,
        output oMAC_ValidRd, oMAC_AddrRd, oMAC_TagRd, oMAC_LenRd, oMAC_QoSRd,
        input  iMAC_ReadyRd,
        input  iMAC_ValidRsp, iMAC_TagRsp, iMAC_DataRsp, iMAC_StatusRsp, iMAC_EoD,
        output oMAC_ReadyRsp,
        output oValidRsp, oTagRsp, oDataRsp, oStatusRsp, oEoD,
        input  iReadyRsp,
        output oErrRsp
    );

    modport master (
        output iValidRd, iAddrRd, iTagRd, iLenRd, iQoSRd,
        input  oReadyRd,
        input  oMAC_ValidRd, oMAC_AddrRd, oMAC_TagRd, oMAC_LenRd, oMAC_QoSRd,
        output iMAC_ReadyRd,
        output iMAC_ValidRsp, iMAC_TagRsp, iMAC_DataRsp, iMAC_StatusRsp, iMAC_EoD,
        input  oMAC_ReadyRsp,
        input  oValidRsp, oTagRsp, oDataRsp, oStatusRsp, oEoD,
        output iReadyRsp,
        input  oErrRsp
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: N-initiator read-channel arbiter in front of the MAC read port.
// Requests are chosen by QoS. Equal QoS values are resolved round-robin.
// Each initiator has a limit on outstanding reads.
// The winning request is held in a one-deep register that drives the MAC.
// The source index is placed in the upper tag bits, and responses are routed
// back to the initiator by combinational logic.
// Optional feature: define RD_AGING_EN to promote requests that have waited
// AGE_TH cycles to the highest QoS.
//
// Output register state table:
//   state    | meaning
//   ST_EMPTY | no request is presented to the MAC
//   ST_FULL  | oMAC_ValidRd is high, fields hold until iMAC_ReadyRd
module mem_rd_arbiter #(
    parameter int NUM_INIT = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TW       = 4,
    parameter int QW       = 4,
    parameter int MAX_OUT  = 8,
    parameter int AGE_TH   = 15
) (
    input  logic            clk,
    input  logic            reset,
    mem_rd_arbiter_if.slave bus
);
    localparam int SW = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
    localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUT);

    typedef logic [SW-1:0] idx_t;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    if (NUM_INIT < 2 || NUM_INIT > 8) begin : g_chk_num_init
        $error("mem_rd_arbiter: NUM_INIT must be 2..8");
    end
    if (MAX_OUT < 1 || MAX_OUT > 255) begin : g_chk_max_out
        $error("mem_rd_arbiter: MAX_OUT must be 1..255");
    end
    if (AGE_TH < 1) begin : g_chk_age_th
        $error("mem_rd_arbiter: AGE_TH must be at least 1");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_out_cnt [NUM_INIT];
    idx_t                r_rr_ptr;
    logic [AW-1:0]       r_mac_addr;
    logic [SW+TW-1:0]    r_mac_tag;
    logic [1:0]          r_mac_len;
    logic [QW-1:0]       r_mac_qos;
    logic                r_err;

    logic [NUM_INIT-1:0] w_elig;
    logic [NUM_INIT-1:0] w_grant_oh;
    logic [NUM_INIT-1:0] w_dec_oh;
    logic [NUM_INIT-1:0] w_valid_rsp;
    logic [NUM_INIT-1:0] w_eod;
    logic [QW-1:0]       w_eff_qos [NUM_INIT];
    logic                w_arb_en;
    logic                w_win_found;
    logic                w_grant;
    idx_t                w_win_idx;
    logic [QW-1:0]       w_win_qos;
    int                  w_scan_idx;
    idx_t                w_rsp_src;
    logic                w_src_ok;
    logic                w_ready_rsp;
    logic                w_rsp_done;

    // An initiator may compete only while its outstanding count is below the limit.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_INIT; i++) begin
            w_elig[i] = bus.iValidRd[i] & (r_out_cnt[i] < MAX_OUT_C);
        end
    end

`ifdef RD_AGING_EN
    logic [7:0] r_age [NUM_INIT];

    // Age counts the cycles an eligible request waits. It clears on grant or when valid drops.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INIT; i++) begin
            if (reset || !bus.iValidRd[i] || w_grant_oh[i]) begin
                r_age[i] <= 8'd0;
            end else if (w_elig[i] && r_age[i] != 8'hFF) begin
                r_age[i] <= r_age[i] + 8'd1;
            end
        end
    end

    // Requests that have waited too long compete at the highest QoS.
    always_comb begin
        for (int i = 0; i < NUM_INIT; i++) begin
            w_eff_qos[i] = bus.iQoSRd[i*QW +: QW];
            if (int'(r_age[i]) >= AGE_TH) begin
                w_eff_qos[i] = '1;
            end
        end
    end
`else
    // Without aging, the effective QoS is the QoS the initiator requested.
    always_comb begin
        for (int i = 0; i < NUM_INIT; i++) begin
            w_eff_qos[i] = bus.iQoSRd[i*QW +: QW];
        end
    end
`endif

    // Scan in round-robin order starting after rrPtr. A candidate replaces the
    // current best only on strictly higher QoS, so the earliest one wins a tie.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_qos   = '0;
        w_scan_idx  = 0;
        for (int k = 0; k < NUM_INIT; k++) begin
            w_scan_idx = (int'(r_rr_ptr) + 1 + k) % NUM_INIT;
            if (w_elig[w_scan_idx] && (!w_win_found || w_eff_qos[w_scan_idx] > w_win_qos)) begin
                w_win_found = 1'b1;
                w_win_idx   = idx_t'(w_scan_idx);
                w_win_qos   = w_eff_qos[w_scan_idx];
            end
        end
    end

    assign w_arb_en = (r_state == ST_EMPTY) | bus.iMAC_ReadyRd;
    assign w_grant  = w_arb_en & w_win_found & ~reset;

    // The grant is a one-hot vector on the winner, or zero when nothing is granted.
    always_comb begin
        w_grant_oh = '0;
        for (int i = 0; i < NUM_INIT; i++) begin
            w_grant_oh[i] = w_grant && (w_win_idx == idx_t'(i));
        end
    end

    // Output register state: this flop holds the enum state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A grant refills the register. The MAC accepting with no new grant empties it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_grant && bus.iMAC_ReadyRd) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Load the winner's request fields and remember the winner for round-robin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mac_addr <= '0;
            r_mac_tag  <= '0;
            r_mac_len  <= '0;
            r_mac_qos  <= '0;
            r_rr_ptr   <= idx_t'(NUM_INIT - 1);
        end else if (w_grant) begin
            r_mac_addr <= bus.iAddrRd[w_win_idx*AW +: AW];
            r_mac_tag  <= {w_win_idx, bus.iTagRd[w_win_idx*TW +: TW]};
            r_mac_len  <= bus.iLenRd[w_win_idx*2 +: 2];
            r_mac_qos  <= bus.iQoSRd[w_win_idx*QW +: QW];
            r_rr_ptr   <= w_win_idx;
        end
    end

    assign w_rsp_src = bus.iMAC_TagRsp[SW+TW-1:TW];
    assign w_src_ok  = int'(w_rsp_src) < NUM_INIT;

    // Steer the response beat to its source. A beat with an unknown source is
    // accepted and dropped so the MAC cannot stall on it.
    always_comb begin
        w_valid_rsp = '0;
        w_eod       = '0;
        w_dec_oh    = '0;
        w_ready_rsp = 1'b1;
        for (int i = 0; i < NUM_INIT; i++) begin
            if (w_src_ok && w_rsp_src == idx_t'(i)) begin
                w_valid_rsp[i] = bus.iMAC_ValidRsp & ~reset;
                w_eod[i]       = bus.iMAC_EoD;
                w_ready_rsp    = bus.iReadyRsp[i];
            end
        end
        w_rsp_done = bus.iMAC_ValidRsp & w_ready_rsp & bus.iMAC_EoD & w_src_ok;
        for (int i = 0; i < NUM_INIT; i++) begin
            w_dec_oh[i] = w_rsp_done && (w_rsp_src == idx_t'(i));
        end
    end

    // Outstanding count: +1 on grant, -1 on the final response beat, no change
    // when both happen. The count never goes below zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INIT; i++) begin
            if (reset) begin
                r_out_cnt[i] <= 8'd0;
            end else if (w_grant_oh[i] && !w_dec_oh[i]) begin
                r_out_cnt[i] <= r_out_cnt[i] + 8'd1;
            end else if (!w_grant_oh[i] && w_dec_oh[i] && r_out_cnt[i] != 8'd0) begin
                r_out_cnt[i] <= r_out_cnt[i] - 8'd1;
            end
        end
    end

    // Sticky error: a response arrived carrying a source index with no initiator behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (bus.iMAC_ValidRsp && !w_src_ok) begin
            r_err <= 1'b1;
        end
    end

    assign bus.oReadyRd      = w_grant_oh;
    assign bus.oMAC_ValidRd  = (r_state == ST_FULL);
    assign bus.oMAC_AddrRd   = r_mac_addr;
    assign bus.oMAC_TagRd    = r_mac_tag;
    assign bus.oMAC_LenRd    = r_mac_len;
    assign bus.oMAC_QoSRd    = r_mac_qos;
    assign bus.oMAC_ReadyRsp = w_ready_rsp;
    assign bus.oValidRsp     = w_valid_rsp;
    assign bus.oEoD          = w_eod;
    assign bus.oTagRsp       = {NUM_INIT{bus.iMAC_TagRsp[TW-1:0]}};
    assign bus.oDataRsp      = {NUM_INIT{bus.iMAC_DataRsp}};
    assign bus.oStatusRsp    = {NUM_INIT{bus.iMAC_StatusRsp}};
    assign bus.oErrRsp       = r_err;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed scenarios plus randomized traffic, checked against a
// behavioural model of arbitration, outstanding counts and the MAC register.
// NUM_INIT=3 so that source index 3 is encodable yet out of range; MAX_OUT=2.
module tb_mem_rd_arbiter;
    localparam int N       = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TW      = 4;
    localparam int QW      = 4;
    localparam int SW      = 2;
    localparam int MAX_OUT = 2;
    localparam int AGE_TH  = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.NUM_INIT(N), .AW(AW), .DW(DW), .TW(TW), .QW(QW)) bus();

    mem_rd_arbiter #(
        .NUM_INIT(N), .AW(AW), .DW(DW), .TW(TW), .QW(QW),
        .MAX_OUT(MAX_OUT), .AGE_TH(AGE_TH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // reference model state
    int               m_cnt [N];
    int               m_age [N];
    int               m_rr;
    bit               m_vld;
    bit               m_err;
    logic [AW-1:0]    m_addr;
    logic [SW+TW-1:0] m_tag;
    logic [1:0]       m_len;
    logic [QW-1:0]    m_qos;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_age[i] = 0;
        end
        m_rr = N - 1;
        m_vld = 0;
        m_err = 0;
        m_addr = '0;
        m_tag = '0;
        m_len = '0;
        m_qos = '0;
    endfunction

    function automatic int eff_qos(int i);
        int q;
        q = int'(bus.iQoSRd[i*QW +: QW]);
`ifdef RD_AGING_EN
        if (m_age[i] >= AGE_TH) q = (1 << QW) - 1;
`endif
        return q;
    endfunction

    // distance from the round-robin start position; smaller wins a QoS tie
    function automatic int rr_dist(int i);
        return (i - m_rr - 1 + 2 * N) % N;
    endfunction

    function automatic int model_winner();
        int best;
        best = -1;
        if (m_vld && !bus.iMAC_ReadyRd) return -1;
        for (int i = 0; i < N; i++) begin
            if (bus.iValidRd[i] && m_cnt[i] < MAX_OUT) begin
                if (best < 0 || eff_qos(i) > eff_qos(best) ||
                    (eff_qos(i) == eff_qos(best) && rr_dist(i) < rr_dist(best)))
                    best = i;
            end
        end
        return best;
    endfunction

    function automatic int rsp_src();
        return int'(bus.iMAC_TagRsp[SW+TW-1:TW]);
    endfunction

    function automatic bit exp_rsp_ready();
        if (rsp_src() >= N) return 1'b1;
        return bus.iReadyRsp[rsp_src()];
    endfunction

    // advance the model by one clock using the inputs currently applied
    function automatic void model_clock(int win);
        int  src;
        bit  done;
        src = rsp_src();
        done = bus.iMAC_ValidRsp && bus.iMAC_EoD && (src < N) && exp_rsp_ready();
        if (bus.iMAC_ValidRsp && src >= N) m_err = 1;
        for (int i = 0; i < N; i++) begin
            if (!bus.iValidRd[i] || win == i) m_age[i] = 0;
            else if (m_cnt[i] < MAX_OUT && m_age[i] < 255) m_age[i]++;
        end
        for (int i = 0; i < N; i++) begin
            if (win == i && !(done && src == i)) m_cnt[i]++;
            else if (win != i && done && src == i && m_cnt[i] > 0) m_cnt[i]--;
        end
        if (win >= 0) begin
            m_vld = 1;
            m_addr = bus.iAddrRd[win*AW +: AW];
            m_tag = {SW'(win), bus.iTagRd[win*TW +: TW]};
            m_len = bus.iLenRd[win*2 +: 2];
            m_qos = bus.iQoSRd[win*QW +: QW];
            m_rr = win;
        end else if (m_vld && bus.iMAC_ReadyRd) begin
            m_vld = 0;
        end
    endfunction

    task automatic idle_inputs();
        bus.iValidRd = '0;
        bus.iAddrRd = '0;
        bus.iTagRd = '0;
        bus.iLenRd = '0;
        bus.iQoSRd = '0;
        bus.iMAC_ReadyRd = 1'b0;
        bus.iMAC_ValidRsp = 1'b0;
        bus.iMAC_TagRsp = '0;
        bus.iMAC_DataRsp = '0;
        bus.iMAC_StatusRsp = '0;
        bus.iMAC_EoD = 1'b0;
        bus.iReadyRsp = '0;
    endtask

    // leaves time at posedge+1 with reset released
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.iValidRd = '1;
        bus.iQoSRd = 12'h321;
        bus.iMAC_ReadyRd = 1'b1;
        bus.iMAC_ValidRsp = 1'b1;
        bus.iMAC_TagRsp = {2'd1, 4'h3};
        bus.iReadyRsp = '1;
        @(posedge clk);
        #3;
        checks++;
        if (bus.oReadyRd !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 000", bus.oReadyRd);
        end
        checks++;
        if (bus.oValidRsp !== 3'b000) begin
            errors++;
            $display("FAIL reset_validrsp: got %b expected 000", bus.oValidRsp);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        checks++;
        if (bus.oMAC_ValidRd !== 1'b0 || bus.oReadyRd !== 3'b000 || bus.oErrRsp !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got mac_valid=%b ready=%b err=%b expected 0 000 0",
                     bus.oMAC_ValidRd, bus.oReadyRd, bus.oErrRsp);
        end
        checks++;
        if (bus.oMAC_AddrRd !== '0 || bus.oMAC_TagRd !== '0 || bus.oMAC_LenRd !== '0 || bus.oMAC_QoSRd !== '0) begin
            errors++;
            $display("FAIL reset_fields: got addr=%h tag=%h len=%h qos=%h expected all 0",
                     bus.oMAC_AddrRd, bus.oMAC_TagRd, bus.oMAC_LenRd, bus.oMAC_QoSRd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_qos_priority();
        logic [AW-1:0] a0;
        logic [TW-1:0] t0;
        do_reset();
        a0 = $urandom;
        t0 = TW'($urandom);
        bus.iValidRd = 3'b011;
        bus.iQoSRd = {4'd0, 4'd3, 4'd5};
        bus.iAddrRd = {32'h0, 32'hBEEF_0001, a0};
        bus.iTagRd = {4'h0, 4'h9, t0};
        bus.iLenRd = {2'd0, 2'd1, 2'd2};
        bus.iMAC_ReadyRd = 1'b1;
        #2;
        checks++;
        if (bus.oReadyRd !== 3'b001) begin
            errors++;
            $display("FAIL qos_grant: got %b expected 001", bus.oReadyRd);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.oMAC_ValidRd !== 1'b1 || bus.oMAC_TagRd !== {2'd0, t0} || bus.oMAC_QoSRd !== 4'd5 ||
            bus.oMAC_AddrRd !== a0 || bus.oMAC_LenRd !== 2'd2) begin
            errors++;
            $display("FAIL qos_mac_req: got v=%b tag=%h qos=%0d addr=%h len=%0d expected 1 %h 5 %h 2",
                     bus.oMAC_ValidRd, bus.oMAC_TagRd, bus.oMAC_QoSRd, bus.oMAC_AddrRd, bus.oMAC_LenRd,
                     {2'd0, t0}, a0);
        end
        // tie between 1 and 2 at a higher QoS; rrPtr now 0 so initiator 1 is first
        bus.iValidRd = 3'b111;
        bus.iQoSRd = {4'd7, 4'd7, 4'd2};
        #2;
        checks++;
        if (bus.oReadyRd !== 3'b010) begin
            errors++;
            $display("FAIL qos_tie_grant: got %b expected 010", bus.oReadyRd);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.oMAC_TagRd !== {2'd1, 4'h9} || bus.oMAC_QoSRd !== 4'd7) begin
            errors++;
            $display("FAIL qos_tie_mac: got tag=%h qos=%0d expected 19 7", bus.oMAC_TagRd, bus.oMAC_QoSRd);
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        bus.iValidRd = 3'b011;
        bus.iQoSRd = {4'd0, 4'd4, 4'd4};
        bus.iMAC_ReadyRd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = '0;
            exp[k % 2] = 1'b1;
            #2;
            checks++;
            if (bus.oReadyRd !== exp) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b expected %b", k, bus.oReadyRd, exp);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.oMAC_ValidRd !== 1'b1 || int'(bus.oMAC_TagRd[TW +: SW]) != k % 2) begin
                errors++;
                $display("FAIL rr_mac%0d: got v=%b src=%0d expected 1 %0d",
                         k, bus.oMAC_ValidRd, bus.oMAC_TagRd[TW +: SW], k % 2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_max_out();
        logic [N-1:0]  exp;
        logic [DW-1:0] d;
        do_reset();
        bus.iValidRd = 3'b010;
        bus.iQoSRd = {4'd0, 4'd1, 4'd0};
        bus.iMAC_ReadyRd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = (k < MAX_OUT) ? 3'b010 : 3'b000;
            #2;
            checks++;
            if (bus.oReadyRd !== exp) begin
                errors++;
                $display("FAIL maxout_grant%0d: got %b expected %b", k, bus.oReadyRd, exp);
            end
            @(posedge clk);
            #1;
        end
        d = $urandom;
        bus.iMAC_ValidRsp = 1'b1;
        bus.iMAC_TagRsp = {2'd1, 4'h5};
        bus.iMAC_DataRsp = d;
        bus.iMAC_StatusRsp = 2'd2;
        bus.iMAC_EoD = 1'b1;
        bus.iReadyRsp = 3'b010;
        #2;
        checks++;
        if (bus.oValidRsp !== 3'b010 || bus.oEoD !== 3'b010 || bus.oMAC_ReadyRsp !== 1'b1 || bus.oReadyRd !== 3'b000) begin
            errors++;
            $display("FAIL maxout_rsp: got vrsp=%b eod=%b rdy=%b grant=%b expected 010 010 1 000",
                     bus.oValidRsp, bus.oEoD, bus.oMAC_ReadyRsp, bus.oReadyRd);
        end
        checks++;
        if (bus.oTagRsp[TW +: TW] !== 4'h5 || bus.oDataRsp[DW +: DW] !== d || bus.oStatusRsp[2 +: 2] !== 2'd2) begin
            errors++;
            $display("FAIL maxout_rsp_fields: got tag=%h data=%h st=%0d expected 5 %h 2",
                     bus.oTagRsp[TW +: TW], bus.oDataRsp[DW +: DW], bus.oStatusRsp[2 +: 2], d);
        end
        @(posedge clk);
        #1;
        bus.iMAC_ValidRsp = 1'b0;
        bus.iMAC_EoD = 1'b0;
        #2;
        checks++;
        if (bus.oReadyRd !== 3'b010) begin
            errors++;
            $display("FAIL maxout_regrant: got %b expected 010", bus.oReadyRd);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [TW-1:0] t0;
        do_reset();
        a0 = $urandom;
        a1 = $urandom;
        t0 = TW'($urandom);
        bus.iValidRd = 3'b001;
        bus.iQoSRd = {4'd1, 4'd1, 4'd1};
        bus.iAddrRd = {32'h0, a1, a0};
        bus.iTagRd = {4'h0, 4'hC, t0};
        bus.iLenRd = {2'd0, 2'd3, 2'd1};
        bus.iMAC_ReadyRd = 1'b0;
        #2;
        checks++;
        if (bus.oReadyRd !== 3'b001) begin
            errors++;
            $display("FAIL bp_first_grant: got %b expected 001", bus.oReadyRd);
        end
        @(posedge clk);
        #1;
        bus.iValidRd = 3'b011;
        bus.iAddrRd = {32'h0, a1, ~a0};
        for (int k = 0; k < 5; k++) begin
            #2;
            checks++;
            if (bus.oReadyRd !== 3'b000) begin
                errors++;
                $display("FAIL bp_no_grant%0d: got %b expected 000", k, bus.oReadyRd);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.oMAC_ValidRd !== 1'b1 || bus.oMAC_AddrRd !== a0 || bus.oMAC_TagRd !== {2'd0, t0} ||
                bus.oMAC_LenRd !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b addr=%h tag=%h len=%0d expected 1 %h %h 1",
                         k, bus.oMAC_ValidRd, bus.oMAC_AddrRd, bus.oMAC_TagRd, bus.oMAC_LenRd, a0, {2'd0, t0});
            end
        end
        bus.iMAC_ReadyRd = 1'b1;
        #2;
        checks++;
        if (bus.oReadyRd !== 3'b010) begin
            errors++;
            $display("FAIL bp_release_grant: got %b expected 010", bus.oReadyRd);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.oMAC_ValidRd !== 1'b1 || bus.oMAC_AddrRd !== a1 || bus.oMAC_TagRd !== {2'd1, 4'hC}) begin
            errors++;
            $display("FAIL bp_next_req: got v=%b addr=%h tag=%h expected 1 %h 1c",
                     bus.oMAC_ValidRd, bus.oMAC_AddrRd, bus.oMAC_TagRd, a1);
        end
        bus.iValidRd = 3'b000;
        @(posedge clk);
        #1;
        checks++;
        if (bus.oMAC_ValidRd !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: got %b expected 0", bus.oMAC_ValidRd);
        end
        idle_inputs();
    endtask

    task automatic test_rsp_routing();
        do_reset();
        bus.iMAC_ValidRsp = 1'b1;
        bus.iMAC_EoD = 1'b1;
        bus.iMAC_TagRsp = {2'd2, 4'hA};
        bus.iReadyRsp = 3'b100;
        #2;
        checks++;
        if (bus.oValidRsp !== 3'b100 || bus.oMAC_ReadyRsp !== 1'b1 || bus.oTagRsp[2*TW +: TW] !== 4'hA) begin
            errors++;
            $display("FAIL route_src2: got vrsp=%b rdy=%b tag=%h expected 100 1 a",
                     bus.oValidRsp, bus.oMAC_ReadyRsp, bus.oTagRsp[2*TW +: TW]);
        end
        bus.iMAC_TagRsp = {2'd0, 4'h6};
        bus.iReadyRsp = 3'b110;
        #2;
        checks++;
        if (bus.oValidRsp !== 3'b001 || bus.oMAC_ReadyRsp !== 1'b0) begin
            errors++;
            $display("FAIL route_src0_stall: got vrsp=%b rdy=%b expected 001 0", bus.oValidRsp, bus.oMAC_ReadyRsp);
        end
        @(posedge clk);
        #1;
        bus.iMAC_TagRsp = {2'd3, 4'h1};
        bus.iReadyRsp = 3'b000;
        #2;
        checks++;
        if (bus.oValidRsp !== 3'b000 || bus.oMAC_ReadyRsp !== 1'b1 || bus.oErrRsp !== 1'b0) begin
            errors++;
            $display("FAIL route_bad_src: got vrsp=%b rdy=%b err=%b expected 000 1 0",
                     bus.oValidRsp, bus.oMAC_ReadyRsp, bus.oErrRsp);
        end
        @(posedge clk);
        #1;
        bus.iMAC_ValidRsp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.oErrRsp !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky%0d: got %b expected 1", k, bus.oErrRsp);
            end
            @(posedge clk);
            #1;
        end
        do_reset();
        checks++;
        if (bus.oErrRsp !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b expected 0", bus.oErrRsp);
        end
    endtask

`ifdef RD_AGING_EN
    task automatic test_aging();
        logic [N-1:0] exp;
        do_reset();
        bus.iValidRd = 3'b011;
        bus.iQoSRd = {4'd0, 4'd9, 4'd2};
        bus.iMAC_ReadyRd = 1'b1;
        bus.iMAC_ValidRsp = 1'b1;
        bus.iMAC_EoD = 1'b1;
        bus.iMAC_TagRsp = {2'd1, 4'h0};
        bus.iReadyRsp = '1;
        for (int k = 0; k <= AGE_TH; k++) begin
            exp = (k == AGE_TH) ? 3'b001 : 3'b010;
            #2;
            checks++;
            if (bus.oReadyRd !== exp) begin
                errors++;
                $display("FAIL aging_grant%0d: got %b expected %b", k, bus.oReadyRd, exp);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        int           win;
        int           src;
        logic [N-1:0] exp_oh;
        logic [N-1:0] exp_vr;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.iValidRd = N'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.iQoSRd[i*QW +: QW] = QW'($urandom_range(0, 3));
                bus.iAddrRd[i*AW +: AW] = $urandom;
                bus.iTagRd[i*TW +: TW] = TW'($urandom);
                bus.iLenRd[i*2 +: 2] = 2'($urandom);
            end
            bus.iMAC_ReadyRd = ($urandom_range(0, 3) != 0);
            bus.iMAC_ValidRsp = $urandom_range(0, 1) == 1;
            src = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, N - 1);
            bus.iMAC_TagRsp = {SW'(src), TW'($urandom)};
            bus.iMAC_DataRsp = $urandom;
            bus.iMAC_EoD = $urandom_range(0, 1) == 1;
            bus.iReadyRsp = N'($urandom);
            #2;
            win = model_winner();
            exp_oh = '0;
            if (win >= 0) exp_oh[win] = 1'b1;
            exp_vr = '0;
            if (bus.iMAC_ValidRsp && src < N) exp_vr[src] = 1'b1;
            checks++;
            if (bus.oReadyRd !== exp_oh) begin
                errors++;
                $display("FAIL rand_grant c%0d: got %b expected %b", cyc, bus.oReadyRd, exp_oh);
            end
            checks++;
            if (bus.oValidRsp !== exp_vr || bus.oMAC_ReadyRsp !== exp_rsp_ready()) begin
                errors++;
                $display("FAIL rand_rsp c%0d: got vrsp=%b rdy=%b expected %b %b",
                         cyc, bus.oValidRsp, bus.oMAC_ReadyRsp, exp_vr, exp_rsp_ready());
            end
            model_clock(win);
            @(posedge clk);
            #1;
            checks++;
            if (bus.oMAC_ValidRd !== m_vld || bus.oErrRsp !== m_err) begin
                errors++;
                $display("FAIL rand_state c%0d: got v=%b err=%b expected %b %b",
                         cyc, bus.oMAC_ValidRd, bus.oErrRsp, m_vld, m_err);
            end
            if (m_vld) begin
                checks++;
                if (bus.oMAC_AddrRd !== m_addr || bus.oMAC_TagRd !== m_tag ||
                    bus.oMAC_LenRd !== m_len || bus.oMAC_QoSRd !== m_qos) begin
                    errors++;
                    $display("FAIL rand_req c%0d: got addr=%h tag=%h len=%0d qos=%0d expected %h %h %0d %0d",
                             cyc, bus.oMAC_AddrRd, bus.oMAC_TagRd, bus.oMAC_LenRd, bus.oMAC_QoSRd,
                             m_addr, m_tag, m_len, m_qos);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_qos_priority();
        test_round_robin();
        test_max_out();
        test_backpressure();
        test_rsp_routing();
`ifdef RD_AGING_EN
        test_aging();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
